// File: rtl/noc_loopback_tester.sv
// CHDR loopback traffic generator/checker: TX emits numbered packets, RX checks
// header, sequence continuity, length, payload pattern and tlast placement.
module noc_loopback_tester #(
  parameter int unsigned SEQ_W = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cfg_sid,
  input  logic [7:0]       cfg_len,
  input  logic [15:0]      cfg_count,
  input  logic             rx_stall,
  output logic [63:0]      tx_tdata,
  output logic             tx_tlast,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  input  logic [63:0]      rx_tdata,
  input  logic             rx_tlast,
  input  logic             rx_tvalid,
  output logic             rx_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tx_pkts,
  output logic [CNT_W-1:0] rx_pkts,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY, TX_DONE} tx_state_e;
  typedef enum logic {RX_HDR, RX_PAY} rx_state_e;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d, exp_seq_q, exp_seq_d, rx_seq_q, rx_seq_d;
  logic [7:0]         word_q, word_d, rx_k_q, rx_k_d;
  logic               stop_seen_q, stop_seen_d, pkt_bad_q, pkt_bad_d;
  logic [CNT_W-1:0]   tx_pkts_q, tx_pkts_d, rx_pkts_q, rx_pkts_d, err_cnt_q, err_cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        sid_q;
  logic [7:0]         len_q;
  logic [15:0]        count_q;

  logic               start_ok, tx_beat, rx_beat, count_hit, hdr_ok, pay_bad;
  logic [15:0]        len_bytes;
  logic [11:0]        hdr_seq;
  logic [63:0]        pay_exp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign start_ok  = start & ~busy_q;
  assign len_bytes = ({8'h00, len_q} + 16'd1) << 3;
  assign tx_beat   = tx_tvalid & tx_tready;
  assign rx_tready = ~rx_stall;
  assign rx_beat   = rx_tvalid & rx_tready;
  assign count_hit = (count_q != 16'd0) && ((32'(tx_pkts_q) + 32'd1) == 32'(count_q));

  assign hdr_seq = rx_tdata[59:48];
  assign hdr_ok  = (rx_tdata[63:60] == 4'h0) && (rx_tdata[31:0] == sid_q) &&
                   (rx_tdata[47:32] == len_bytes) && (hdr_seq == 12'(exp_seq_q));
  assign pay_exp = {20'h0, 12'(rx_seq_q), 24'h0, rx_k_q};
  assign pay_bad = (rx_tdata != pay_exp) || (rx_tlast != (rx_k_q == len_q - 8'd1));

  always_comb begin
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
    tx_tdata  = '0;
    case (tx_state_q)
      TX_HDR: begin
        tx_tvalid = 1'b1;
        tx_tdata  = {4'h0, 12'(seq_q), len_bytes, sid_q};
      end
      TX_PAY: begin
        tx_tvalid = 1'b1;
        tx_tdata  = {20'h0, 12'(seq_q), 24'h0, word_q};
        tx_tlast  = (word_q == len_q - 8'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    seq_d       = seq_q;
    word_d      = word_q;
    stop_seen_d = stop_seen_q;
    tx_pkts_d   = tx_pkts_q;
    case (tx_state_q)
      TX_IDLE, TX_DONE: begin
        if (start_ok) begin
          tx_state_d  = TX_HDR;
          seq_d       = '0;
          stop_seen_d = 1'b0;
          tx_pkts_d   = '0;
        end
      end
      TX_HDR: begin
        // A header already accepted commits the packet; otherwise stop abandons it.
        if (tx_beat) begin
          tx_state_d  = TX_PAY;
          word_d      = '0;
          stop_seen_d = stop;
        end else if (stop) begin
          tx_state_d = TX_DONE;
        end
      end
      TX_PAY: begin
        if (tx_beat && tx_tlast) begin
          seq_d      = seq_q + SEQ_W'(1);
          tx_pkts_d  = sat_inc(tx_pkts_q);
          tx_state_d = (count_hit || stop_seen_q || stop) ? TX_DONE : TX_HDR;
        end else begin
          if (tx_beat) word_d = word_q + 8'd1;
          stop_seen_d = stop_seen_q | stop;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    exp_seq_d  = exp_seq_q;
    rx_seq_d   = rx_seq_q;
    rx_k_d     = rx_k_q;
    pkt_bad_d  = pkt_bad_q;
    rx_pkts_d  = rx_pkts_q;
    err_cnt_d  = err_cnt_q;
    if (start_ok) begin
      rx_state_d = RX_HDR;
      exp_seq_d  = '0;
      pkt_bad_d  = 1'b0;
      rx_pkts_d  = '0;
      err_cnt_d  = '0;
    end else if (rx_beat) begin
      if (!(busy_q || done_q)) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end else if (rx_state_q == RX_HDR) begin
        // Resync to the received seq so a single gap costs a single error.
        exp_seq_d = SEQ_W'(hdr_seq) + SEQ_W'(1);
        rx_seq_d  = SEQ_W'(hdr_seq);
        rx_k_d    = '0;
        if (rx_tlast) begin
          rx_pkts_d = sat_inc(rx_pkts_q);
          err_cnt_d = sat_inc(err_cnt_q);
        end else begin
          rx_state_d = RX_PAY;
          pkt_bad_d  = ~hdr_ok;
        end
      end else begin
        if (rx_tlast) begin
          rx_state_d = RX_HDR;
          rx_pkts_d  = sat_inc(rx_pkts_q);
          if (pkt_bad_q || pay_bad) err_cnt_d = sat_inc(err_cnt_q);
        end else begin
          pkt_bad_d = pkt_bad_q | pay_bad;
          rx_k_d    = rx_k_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (start_ok) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q && (tx_state_q == TX_DONE) && (rx_pkts_q == tx_pkts_q)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_HDR;
      seq_q       <= '0;
      exp_seq_q   <= '0;
      rx_seq_q    <= '0;
      word_q      <= '0;
      rx_k_q      <= '0;
      stop_seen_q <= 1'b0;
      pkt_bad_q   <= 1'b0;
      tx_pkts_q   <= '0;
      rx_pkts_q   <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sid_q       <= '0;
      len_q       <= 8'd1;
      count_q     <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      seq_q       <= seq_d;
      exp_seq_q   <= exp_seq_d;
      rx_seq_q    <= rx_seq_d;
      word_q      <= word_d;
      rx_k_q      <= rx_k_d;
      stop_seen_q <= stop_seen_d;
      pkt_bad_q   <= pkt_bad_d;
      tx_pkts_q   <= tx_pkts_d;
      rx_pkts_q   <= rx_pkts_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (start_ok) begin
        sid_q   <= cfg_sid;
        len_q   <= (cfg_len == 8'd0) ? 8'd1 : cfg_len;
        count_q <= cfg_count;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign tx_pkts = tx_pkts_q;
  assign rx_pkts = rx_pkts_q;
  assign err_cnt = err_cnt_q;
  assign err     = (err_cnt_q != '0);

endmodule

// File: tb/tb_noc_loopback_tester.sv
// Scoreboarded bench: a reference packet model predicts TX words, a bench-side
// loop FIFO (with fault injection) feeds RX, and run-end counters are checked.
module tb_noc_loopback_tester;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, rx_stall, tx_tready, rx_tlast, rx_tvalid;
  logic [31:0] cfg_sid;
  logic [7:0]  cfg_len;
  logic [15:0] cfg_count;
  logic [63:0] rx_tdata, tx_tdata;
  logic        tx_tlast, tx_tvalid, rx_tready, busy, done, err;
  logic [15:0] tx_pkts, rx_pkts, err_cnt;

  noc_loopback_tester #(.SEQ_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_sid(cfg_sid), .cfg_len(cfg_len), .cfg_count(cfg_count), .rx_stall(rx_stall),
    .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tlast(rx_tlast), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .busy(busy), .done(done), .tx_pkts(tx_pkts), .rx_pkts(rx_pkts), .err_cnt(err_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [64:0] exp_tx_q[$];
  logic [64:0] loop_q[$];
  int mon_pkt = 0, mon_word = 0, tx_beats = 0;
  int flip_pkt = -1, flip_word = -1, drop_pkt = -1;
  bit rand_mode = 1'b0;
  logic        hold_pend = 1'b0;
  logic [64:0] hold_val;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word k of packet seq: k=0 is the header, k=1..L the payload.
  function automatic logic [64:0] model_word(int seq, int k, int L, logic [31:0] sid);
    logic [63:0] s, w;
    s = 64'(seq % 4096);
    if (k == 0) begin
      w = (s << 48) | (64'(8 * (L + 1)) << 32) | {32'h0, sid};
      return {1'b0, w};
    end
    w = (s << 32) | 64'(k - 1);
    return {(k == L), w};
  endfunction

  task automatic start_run(input int cfg_cnt, input int n_push, input int len_v, input logic [31:0] sid);
    int L;
    L = (len_v == 0) ? 1 : len_v;
    mon_pkt = 0; mon_word = 0; tx_beats = 0;
    for (int p = 0; p < n_push; p++)
      for (int k = 0; k <= L; k++) exp_tx_q.push_back(model_word(p, k, L, sid));
    cfg_count = 16'(cfg_cnt); cfg_len = 8'(len_v); cfg_sid = sid;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(name, 66'(done), 66'(1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tvalid"}, 66'(tx_tvalid), 66'(0));
    chk({tag, "_tlast"},  66'(tx_tlast),  66'(0));
    chk({tag, "_tdata"},  66'(tx_tdata),  66'(0));
    chk({tag, "_busy"},   66'(busy),      66'(0));
    chk({tag, "_done"},   66'(done),      66'(0));
    chk({tag, "_cnts"},   66'({tx_pkts, rx_pkts, err_cnt}), 66'(0));
    chk({tag, "_err"},    66'(err),       66'(0));
  endtask

  task automatic end_checks(input string tag, input int txp, input int rxp, input int ec);
    chk({tag, "_tx_pkts"}, 66'(tx_pkts), 66'(txp));
    chk({tag, "_rx_pkts"}, 66'(rx_pkts), 66'(rxp));
    chk({tag, "_err_cnt"}, 66'(err_cnt), 66'(ec));
    chk({tag, "_err"},     66'(err),     66'(ec != 0));
    chk({tag, "_exp_left"}, 66'(exp_tx_q.size()), 66'(0));
  endtask

  // Loop driver: presents the FIFO head to RX and randomises handshakes.
  initial begin
    tx_tready = 1'b0; rx_stall = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0; rx_tlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_stall  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_tvalid = (loop_q.size() != 0);
      rx_tdata  = rx_tvalid ? loop_q[0][63:0] : '0;
      rx_tlast  = rx_tvalid ? loop_q[0][64] : 1'b0;
    end
  end

  // Monitor: values at negedge are those the DUT sees at the next rising edge.
  initial begin
    logic [64:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) chk("tx_hold", {tx_tvalid, tx_tlast, tx_tdata}, {1'b1, hold_val});
        hold_pend = tx_tvalid & ~tx_tready;
        hold_val  = {tx_tlast, tx_tdata};
        if (rx_tvalid && rx_tready && loop_q.size() != 0) void'(loop_q.pop_front());
        if (tx_tvalid && tx_tready) begin
          tx_beats++;
          w = {tx_tlast, tx_tdata};
          if (exp_tx_q.size() == 0) chk("tx_extra", {1'b0, w}, 66'h3_FFFF_FFFF_FFFF_FFFF);
          else chk("tx_word", {1'b0, w}, {1'b0, exp_tx_q.pop_front()});
          if (mon_pkt == flip_pkt && mon_word == flip_word) w[0] = ~w[0];
          if (mon_pkt != drop_pkt) loop_q.push_back(w);
          if (tx_tlast) begin mon_pkt++; mon_word = 0; end
          else mon_word++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_sid = '0; cfg_len = '0; cfg_count = '0;
    repeat (3) @(posedge clk);
    #1 check_reset("rst0");
    @(negedge clk) rst_n = 1'b1;

    // 1: ideal loopback, three packets of four payload words
    start_run(3, 3, 4, 32'hCAFE_0001);
    wait_done("t1_done", 300);
    end_checks("t1", 3, 3, 0);
    chk("t1_busy", 66'(busy), 66'(0));
    chk("t1_beats", 66'(tx_beats), 66'(15));

    // 2: random backpressure on both sides
    rand_mode = 1'b1;
    start_run(100, 100, 1, 32'h1234_5678);
    wait_done("t2_done", 6000);
    end_checks("t2", 100, 100, 0);
    rand_mode = 1'b0;

    // 3: corrupt payload word 2 of packet 5
    flip_pkt = 5; flip_word = 3;
    start_run(8, 8, 4, 32'h0000_00A5);
    wait_done("t3_done", 500);
    end_checks("t3", 8, 8, 1);
    flip_pkt = -1; flip_word = -1;

    // 4: drop packet 7; run never completes
    drop_pkt = 7;
    start_run(10, 10, 2, 32'hDEAD_BEEF);
    n = 0;
    while ((exp_tx_q.size() != 0 || loop_q.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("t4_drain", 66'(n < 1000), 66'(1));
    end_checks("t4", 10, 9, 1);
    chk("t4_busy", 66'(busy), 66'(1));
    chk("t4_done", 66'(done), 66'(0));
    drop_pkt = -1;
    @(negedge clk) rst_n = 1'b0;
    loop_q.delete(); exp_tx_q.delete();
    @(negedge clk) check_reset("rst1");
    rst_n = 1'b1;

    // 5: continuous run, stop during payload of packet 10
    start_run(0, 11, 3, 32'h5555_AAAA);
    n = 0;
    while (!(mon_pkt == 10 && mon_word >= 1) && n < 2000) begin @(posedge clk); #2; n++; end
    stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
    wait_done("t5_done", 500);
    end_checks("t5", 11, 11, 0);
    repeat (20) @(negedge clk);
    chk("t5_idle_tvalid", 66'(tx_tvalid), 66'(0));
    chk("t5_beats", 66'(tx_beats), 66'(44));

    // 6: async reset mid-payload, then restart from seq 0 with cfg_len=0
    start_run(0, 50, 5, 32'h0F0F_0F0F);
    n = 0;
    while (!(mon_pkt == 2 && mon_word >= 3) && n < 2000) begin @(posedge clk); #2; n++; end
    rst_n = 1'b0;
    loop_q.delete(); exp_tx_q.delete();
    #1 check_reset("t6_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(2, 2, 0, 32'h0000_0006);
    wait_done("t6_done", 200);
    end_checks("t6", 2, 2, 0);
    chk("t6_beats", 66'(tx_beats), 66'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
